// File: rtl/divider.sv
// Unsigned restoring divider with a one-entry last-operands cache.
// One quotient bit per cycle, MSB first; divide-by-zero and cache hits finish in one cycle.
module divider #(
  parameter int WIDTH    = 32,
  parameter int CACHING  = 1,
  parameter bit INIT_VLD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             zeroErr,
  output logic             valid
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic             hit_q, hit_d;
  logic             cvld_q, cvld_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             zerr_q, zerr_d;
  logic             vld_q, vld_d;

  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] prem_q, prem_d;

  logic [2*WIDTH-1:0] step;
  logic               cache_hit;

  // One restoring step: returns {next partial remainder, next dividend/quotient shift reg}.
  // When the subtraction succeeds the true difference is below den, so WIDTH bits suffice.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] prem,
                                                  input logic [WIDTH-1:0] num,
                                                  input logic [WIDTH-1:0] den);
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] diff;
    logic             ge;
    sh   = {prem, num[WIDTH-1]};
    ge   = (sh >= {1'b0, den});
    diff = sh[WIDTH-1:0] - den;
    return {(ge ? diff : sh[WIDTH-1:0]), num[WIDTH-2:0], ge};
  endfunction

  // The latched operands double as the cache tags; cvld marks them as a finished result.
  assign cache_hit = (CACHING != 0) && cvld_q && (dividend == opa_q) && (divisor == opb_q);
  assign step      = div_step(prem_q, num_q, opb_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    hit_d   = 1'b0;
    cvld_d  = cvld_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    zerr_d  = zerr_q;
    vld_d   = vld_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    num_d   = num_q;
    prem_d  = prem_q;
    case (state_q)
      IDLE: begin
        if (hit_q) vld_d = 1'b1;
        if (start) begin
          vld_d = 1'b0;
          if (cache_hit) begin
            hit_d = 1'b1;
          end else begin
            opa_d   = dividend;
            opb_d   = divisor;
            num_d   = dividend;
            prem_d  = '0;
            cnt_d   = '0;
            dz_d    = (divisor == '0);
            cvld_d  = 1'b0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (dz_q) begin
          quot_d  = '1;
          rem_d   = opa_q;
          zerr_d  = 1'b1;
          vld_d   = 1'b1;
          cvld_d  = 1'b1;
          state_d = IDLE;
        end else begin
          prem_d = step[2*WIDTH-1:WIDTH];
          num_d  = step[WIDTH-1:0];
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            quot_d  = step[WIDTH-1:0];
            rem_d   = step[2*WIDTH-1:WIDTH];
            zerr_d  = 1'b0;
            vld_d   = 1'b1;
            cvld_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      hit_q   <= 1'b0;
      cvld_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      zerr_q  <= 1'b0;
      vld_q   <= INIT_VLD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      hit_q   <= hit_d;
      cvld_q  <= cvld_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      zerr_q  <= zerr_d;
      vld_q   <= vld_d;
    end
  end

  // Working datapath registers are only meaningful while BUSY, so they carry no reset.
  always_ff @(posedge clk) begin
    opa_q  <= opa_d;
    opb_q  <= opb_d;
    num_q  <= num_d;
    prem_q <= prem_d;
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign zeroErr   = zerr_q;
  assign valid     = vld_q;

endmodule

// File: tb/tb_divider.sv
// Directed and randomized bench for divider against a plain-arithmetic reference model.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        zeroErr;
  logic        valid;

  always #5 clk = ~clk;

  divider #(.WIDTH(32), .CACHING(1), .INIT_VLD(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .zeroErr(zeroErr), .valid(valid)
  );

  int nvec = 0;
  int nerr = 0;

  logic [31:0] m_q = '0;
  logic [31:0] m_r = '0;
  logic        m_z = 1'b0;
  bit          m_cv = 1'b0;
  logic [31:0] m_ca = '0;
  logic [31:0] m_cb = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_r = '0; m_z = 1'b0; m_cv = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit poke,
                        input string tag);
    int n;
    int exp_lat;
    if (m_cv && a == m_ca && b == m_cb) begin
      exp_lat = 1;
    end else if (b == 0) begin
      exp_lat = 1; m_q = '1; m_r = a; m_z = 1'b1;
    end else begin
      exp_lat = 32; m_q = a / b; m_r = a % b; m_z = 1'b0;
    end
    m_cv = 1'b1; m_ca = a; m_cb = b;
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_vclr"}, {31'b0, valid}, 32'd0);
    n = 0;
    while (valid !== 1'b1 && n < 40) begin
      if (poke && n == 5) begin
        start = 1'b1; dividend = $urandom; divisor = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_q"}, quotient, m_q);
    check({tag, "_r"}, remainder, m_r);
    check({tag, "_z"}, {31'b0, zeroErr}, {31'b0, m_z});
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_q"}, quotient, 32'd0);
    check({tag, "_r"}, remainder, 32'd0);
    check({tag, "_z"}, {31'b0, zeroErr}, 32'd0);
    check({tag, "_v"}, {31'b0, valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int mode;

    // Asynchronous reset with no clock edge involved.
    #1 rst = 1'b0;
    #1 check_reset_outs("rst0");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_op(32'h10000001, 32'h20000001, 1'b0, "r030");
    repeat (3) @(negedge clk);
    check("hold_v", {31'b0, valid}, 32'd1);
    check("hold_r", remainder, 32'h10000001);

    run_op(32'd100, 32'd7, 1'b0, "r031");
    run_op(32'd100, 32'd7, 1'b0, "r031hit");
    run_op(32'h12345678, 32'd0, 1'b0, "r032");
    run_op(32'hFFFFFFFF, 32'd1, 1'b1, "r033");

    // Abort a division ten cycles in.
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1 check_reset_outs("abort");
    model_reset();
    @(negedge clk);
    check("abort_v1", {31'b0, valid}, 32'd0);
    @(negedge clk);
    check("abort_v2", {31'b0, valid}, 32'd0);
    rst = 1'b1;
    run_op(32'd1000, 32'd3, 1'b0, "r034");

    // Reset while idle must also forget the cached operands.
    rst = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst = 1'b1;
    run_op(32'd1000, 32'd3, 1'b0, "cclr");

    for (int i = 0; i < 24; i++) begin
      mode = int'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      case (mode)
        0: b = 32'd0;
        1: begin a = m_ca; b = m_cb; end
        2: b = $urandom_range(1, 15);
        3: a = b >> $urandom_range(1, 8);
        default: ;
      endcase
      run_op(a, b, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits (WIDTH >= 2).
REQ-002 Parameter CACHING, default 1: 1 enables the last-operands cache, 0 disables it.
REQ-003 Parameter INIT_VLD, default 0, value driven on valid while reset is active.
REQ-004 clk  input  1  single clock, all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 start  input  1  one-cycle request to begin a division, sampled on the rising clk edge.
REQ-007 dividend  input  WIDTH  unsigned dividend, sampled when start is accepted.
REQ-008 divisor  input  WIDTH  unsigned divisor, sampled when start is accepted.
REQ-009 quotient  output  WIDTH  registered unsigned quotient of the last completed operation.
REQ-010 remainder  output  WIDTH  registered unsigned remainder of the last completed operation.
REQ-011 zeroErr  output  1  registered; 1 when the last completed operation had divisor == 0.
REQ-012 valid  output  1  registered; 1 when quotient, remainder and zeroErr hold a completed result.

Function
REQ-013 The block SHALL implement a two-state FSM with states IDLE and BUSY, entering IDLE on reset.
REQ-014 In IDLE, start == 1 at a rising edge SHALL be accepted: operands latched, valid cleared on that same edge.
REQ-015 In BUSY, start SHALL be ignored and the latched operands SHALL NOT change.
REQ-016 Division SHALL be unsigned restoring (shift-subtract), one quotient bit per cycle, MSB first.
REQ-017 For a normal operation (divisor != 0, no cache hit), results and valid = 1 SHALL appear exactly WIDTH rising edges after the accepting edge, after which the FSM returns to IDLE.
REQ-018 Results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor.
REQ-019 If divisor == 0 at acceptance, the block SHALL skip iteration and, on the next rising edge, set zeroErr = 1, quotient = all ones, remainder = dividend, valid = 1, and return to IDLE.
REQ-020 zeroErr SHALL be 0 for every result with divisor != 0, and SHALL update together with valid.
REQ-021 With CACHING = 1, the block SHALL store the operands of the last completed operation, with a cache-valid flag cleared by reset.
REQ-022 With CACHING = 1, a start whose dividend and divisor equal the cached operands, with the cache-valid flag set, SHALL be a cache hit.
REQ-023 On a cache hit, the block SHALL stay in IDLE, leave quotient, remainder and zeroErr unchanged, and assert valid = 1 on the next rising edge, giving 1-cycle latency.
REQ-024 With CACHING = 0, every accepted start SHALL perform the full computation.
REQ-025 Outputs SHALL hold their values and valid SHALL stay 1 until the next accepted start; the result needs no acknowledge.
REQ-026 While BUSY, quotient, remainder and zeroErr SHALL keep their previous values; only valid is forced to 0.

Reset
REQ-027 While rst == 0, the block SHALL force quotient = 0, remainder = 0, zeroErr = 0, valid = INIT_VLD, state = IDLE and cache-valid = 0, regardless of clk.
REQ-028 Reset asserted mid-operation SHALL abort the division immediately, with no partial result ever flagged valid.
REQ-029 After rst deasserts, a start SHALL be accepted at the first rising edge where rst == 1.

Verification
REQ-030 Reset, then dividend = 0x10000001, divisor = 0x20000001, start for 1 cycle -> valid = 1 after 32 edges, quotient = 0x00000000, remainder = 0x10000001, zeroErr = 0.
REQ-031 dividend = 100, divisor = 7 -> quotient = 14, remainder = 2, valid after 32 edges; then an identical start with CACHING = 1 -> valid on the next edge, same results.
REQ-032 dividend = 0x12345678, divisor = 0 -> next edge: valid = 1, zeroErr = 1, quotient = 0xFFFFFFFF, remainder = 0x12345678.
REQ-033 dividend = 0xFFFFFFFF, divisor = 1 -> quotient = 0xFFFFFFFF, remainder = 0; start pulsed again while BUSY -> ignored, result unchanged.
REQ-034 Reset asserted 10 cycles into a division -> outputs 0, valid = INIT_VLD, no valid pulse; then a fresh start with the same operands computes fully (cache cleared).
REQ-035 Randomized unsigned operand pairs -> quotient/remainder match a reference model; valid timing per REQ-017, REQ-019 and REQ-023.
